// File: rtl/simd_lane_regfile_mw.sv
// Per-lane multi-wave register file: two registered read ports, one write port with bypass,
// a per-register pending scoreboard, read-only metadata registers and a one-register-per-cycle context clear.
module simd_lane_regfile_mw #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int NUM_WAVES  = 4,
  parameter int WAVE_SIZE  = 32,
  parameter int LANE_WIDTH = 16,
  localparam int AW = $clog2(NUM_REGS),
  localparam int WW = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1,
  localparam int CW = (WAVE_SIZE / LANE_WIDTH > 1) ? $clog2(WAVE_SIZE / LANE_WIDTH) : 1,
  localparam int LW = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1,
  localparam int GP = NUM_REGS - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LW-1:0]         lane_id,
  input  logic [31:0]           block_id,
  input  logic [31:0]           block_dim,
  input  logic [31:0]           wave_base,
  input  logic                  rd_en,
  input  logic [WW-1:0]         rd_wave,
  input  logic [CW-1:0]         rd_cycle,
  input  logic [AW-1:0]         rm_addr,
  input  logic [AW-1:0]         rn_addr,
  output logic [DATA_WIDTH-1:0] rm_data,
  output logic [DATA_WIDTH-1:0] rn_data,
  output logic                  rd_valid,
  output logic                  rd_hazard,
  input  logic                  wr_en,
  input  logic [WW-1:0]         wr_wave,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pend_set,
  input  logic [WW-1:0]         pend_wave,
  input  logic [AW-1:0]         pend_addr,
  input  logic                  clr_req,
  input  logic [WW-1:0]         clr_wave,
  output logic                  clr_busy,
  output logic                  wr_drop
);

  localparam logic [AW-1:0] GP_A    = AW'(GP);
  localparam logic [AW-1:0] GP_LAST = AW'(GP - 1);
  localparam logic [AW-1:0] R_BID   = AW'(GP);
  localparam logic [AW-1:0] R_BDIM  = AW'(GP + 1);
  localparam logic [AW-1:0] R_TID   = AW'(GP + 2);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  logic [DATA_WIDTH-1:0] r_regs [NUM_WAVES][GP];
  logic [GP-1:0]         r_pend [NUM_WAVES];
  logic [DATA_WIDTH-1:0] r_rm_data, r_rn_data;
  logic                  r_rd_valid, r_rd_hazard, r_wr_drop;
  state_t                r_state, w_next_state;
  logic [AW-1:0]         r_idx;
  logic [WW-1:0]         r_clr_wave;

  logic                  w_busy;
  logic                  w_wr_acc;
  logic [31:0]           w_tid;
  logic [AW-1:0]         w_addr [2];
  logic [DATA_WIDTH-1:0] w_rdat [2];
  logic                  w_rpend [2];

  // Writes into the context being cleared are dropped so they never race the clear engine.
  assign w_wr_acc = wr_en && (wr_addr < GP_A) && !(w_busy && (wr_wave == r_clr_wave));
  assign w_tid    = (wave_base + 32'(rd_wave)) * 32'(WAVE_SIZE)
                  + 32'(rd_cycle) * 32'(LANE_WIDTH) + 32'(lane_id);
  assign w_addr[0] = rm_addr;
  assign w_addr[1] = rn_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdat[p]  = '0;
      w_rpend[p] = 1'b0;
      if (w_addr[p] < GP_A) begin
        w_rpend[p] = r_pend[rd_wave][w_addr[p]];
        if (w_wr_acc && (wr_wave == rd_wave) && (wr_addr == w_addr[p]))
          w_rdat[p] = wr_data;
        else
          w_rdat[p] = r_regs[rd_wave][w_addr[p]];
      end else if (w_addr[p] == R_BID) begin
        w_rdat[p] = DATA_WIDTH'($signed(block_id));
      end else if (w_addr[p] == R_BDIM) begin
        w_rdat[p] = DATA_WIDTH'(block_dim);
      end else if (w_addr[p] == R_TID) begin
        w_rdat[p] = DATA_WIDTH'(w_tid);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (clr_req) w_next_state = S_CLEAR;
      S_CLEAR: if (r_idx == GP_LAST) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAVES; w++) begin
        for (int g = 0; g < GP; g++) r_regs[w][g] <= '0;
        r_pend[w] <= '0;
      end
      r_rm_data   <= '0;
      r_rn_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_hazard <= 1'b0;
      r_wr_drop   <= 1'b0;
      r_idx       <= '0;
      r_clr_wave  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_regs[wr_wave][wr_addr] <= wr_data;
        r_pend[wr_wave][wr_addr] <= 1'b0;
      end
      if (w_busy) begin
        r_regs[r_clr_wave][r_idx] <= '0;
        r_pend[r_clr_wave][r_idx] <= 1'b0;
      end
      // Placed last so a load issue wins over a same-cycle clear of the bit.
      if (pend_set && (pend_addr < GP_A))
        r_pend[pend_wave][pend_addr] <= 1'b1;

      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rm_data   <= w_rdat[0];
        r_rn_data   <= w_rdat[1];
        r_rd_hazard <= w_rpend[0] | w_rpend[1];
      end
      r_wr_drop <= wr_en && !w_wr_acc;

      if ((r_state == S_IDLE) && clr_req) begin
        r_clr_wave <= clr_wave;
        r_idx      <= '0;
      end else if (w_busy) begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  assign rm_data   = r_rm_data;
  assign rn_data   = r_rn_data;
  assign rd_valid  = r_rd_valid;
  assign rd_hazard = r_rd_hazard;
  assign wr_drop   = r_wr_drop;
  assign clr_busy  = w_busy;

endmodule

// File: tb/tb_simd_lane_regfile_mw.sv
// Directed bench for simd_lane_regfile_mw: a table of one-cycle vectors plus clear and reset-mid-clear sequences.
module tb_simd_lane_regfile_mw;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  lane_id;
  logic [31:0] block_id, block_dim, wave_base;
  logic        rd_en;
  logic [1:0]  rd_wave;
  logic [0:0]  rd_cycle;
  logic [4:0]  rm_addr, rn_addr;
  logic [63:0] rm_data, rn_data;
  logic        rd_valid, rd_hazard;
  logic        wr_en;
  logic [1:0]  wr_wave;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        pend_set;
  logic [1:0]  pend_wave;
  logic [4:0]  pend_addr;
  logic        clr_req;
  logic [1:0]  clr_wave;
  logic        clr_busy, wr_drop;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simd_lane_regfile_mw dut (
    .clk(clk), .rst(rst), .lane_id(lane_id), .block_id(block_id), .block_dim(block_dim),
    .wave_base(wave_base), .rd_en(rd_en), .rd_wave(rd_wave), .rd_cycle(rd_cycle),
    .rm_addr(rm_addr), .rn_addr(rn_addr), .rm_data(rm_data), .rn_data(rn_data),
    .rd_valid(rd_valid), .rd_hazard(rd_hazard), .wr_en(wr_en), .wr_wave(wr_wave),
    .wr_addr(wr_addr), .wr_data(wr_data), .pend_set(pend_set), .pend_wave(pend_wave),
    .pend_addr(pend_addr), .clr_req(clr_req), .clr_wave(clr_wave), .clr_busy(clr_busy),
    .wr_drop(wr_drop)
  );

  typedef struct packed {
    logic        rd;
    logic [1:0]  rw;
    logic [0:0]  rc;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic        we;
    logic [1:0]  ww;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        ps;
    logic [1:0]  pw;
    logic [4:0]  pa;
    logic        chk;
    logic [63:0] erm;
    logic [63:0] ern;
    logic        ehz;
    logic        edrop;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rd, logic [1:0] rw, logic [0:0] rc, logic [4:0] rm, logic [4:0] rn,
                              logic we, logic [1:0] ww, logic [4:0] wa, logic [63:0] wd,
                              logic ps, logic [1:0] pw, logic [4:0] pa,
                              logic chk, logic [63:0] erm, logic [63:0] ern, logic ehz, logic edrop);
    vec_t v;
    v.rd = rd; v.rw = rw; v.rc = rc; v.rm = rm; v.rn = rn;
    v.we = we; v.ww = ww; v.wa = wa; v.wd = wd;
    v.ps = ps; v.pw = pw; v.pa = pa;
    v.chk = chk; v.erm = erm; v.ern = ern; v.ehz = ehz; v.edrop = edrop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; rd_wave = 0; rd_cycle = 0; rm_addr = 0; rn_addr = 0;
    wr_en = 0; wr_wave = 0; wr_addr = 0; wr_data = 0;
    pend_set = 0; pend_wave = 0; pend_addr = 0;
    clr_req = 0; clr_wave = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd2(input logic [1:0] w, input logic [4:0] a, input logic [4:0] b);
    rd_en = 1; rd_wave = w; rm_addr = a; rn_addr = b;
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle();
    rst = 1;
    lane_id = 4'd5; block_id = 32'hFFFF_FFFF; block_dim = 32'd64; wave_base = 32'd3;

    //            rd rw rc rm  rn  we ww wa  wd                      ps pw pa  chk erm                      ern                      hz dr
    vecs[0]  = mk(0, 0, 0, 0,  0,  1, 2, 5,  64'hDEAD_BEEF,          0, 0, 0,  0,  64'h0,                   64'h0,                   0, 0);
    vecs[1]  = mk(1, 2, 0, 5,  31, 0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'hDEAD_BEEF,           64'h0,                   0, 0);
    vecs[2]  = mk(1, 1, 0, 5,  5,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h0,                   64'h0,                   0, 0);
    vecs[3]  = mk(1, 0, 0, 7,  5,  1, 0, 7,  64'h55,                 0, 0, 0,  1,  64'h55,                  64'h0,                   0, 0);
    vecs[4]  = mk(1, 0, 0, 7,  29, 1, 0, 29, 64'h1,                  0, 0, 0,  1,  64'h55,                  64'd64,                  0, 1);
    vecs[5]  = mk(1, 1, 1, 30, 28, 0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'd149,                 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    vecs[6]  = mk(1, 0, 0, 30, 29, 0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'd101,                 64'd64,                  0, 0);
    vecs[7]  = mk(0, 0, 0, 0,  0,  0, 0, 0,  64'h0,                  1, 0, 3,  0,  64'h0,                   64'h0,                   0, 0);
    vecs[8]  = mk(1, 0, 0, 3,  7,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h0,                   64'h55,                  1, 0);
    vecs[9]  = mk(1, 0, 0, 3,  0,  1, 0, 3,  64'h33,                 0, 0, 0,  1,  64'h33,                  64'h0,                   1, 0);
    vecs[10] = mk(1, 0, 0, 0,  3,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h0,                   64'h33,                  0, 0);
    vecs[11] = mk(0, 0, 0, 0,  0,  1, 0, 3,  64'h44,                 1, 0, 3,  0,  64'h0,                   64'h0,                   0, 0);
    vecs[12] = mk(1, 0, 0, 3,  3,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h44,                  64'h44,                  1, 0);
    vecs[13] = mk(0, 0, 0, 0,  0,  1, 0, 3,  64'h45,                 1, 0, 30, 0,  64'h0,                   64'h0,                   0, 0);
    vecs[14] = mk(1, 0, 0, 30, 3,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'd101,                 64'h45,                  0, 0);
    vecs[15] = mk(0, 0, 0, 0,  0,  1, 3, 27, 64'h2727,               0, 0, 0,  0,  64'h0,                   64'h0,                   0, 0);
    vecs[16] = mk(1, 3, 0, 27, 26, 0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h2727,                64'h0,                   0, 0);
    vecs[17] = mk(1, 3, 0, 28, 27, 1, 3, 28, 64'h9,                  0, 0, 0,  1,  64'hFFFF_FFFF_FFFF_FFFF, 64'h2727,                0, 1);
    vecs[18] = mk(0, 0, 0, 0,  0,  0, 0, 0,  64'h0,                  1, 2, 5,  0,  64'h0,                   64'h0,                   0, 0);
    vecs[19] = mk(1, 1, 0, 5,  6,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h0,                   64'h0,                   0, 0);
    vecs[20] = mk(1, 2, 0, 6,  5,  0, 0, 0,  64'h0,                  0, 0, 0,  1,  64'h0,                   64'hDEAD_BEEF,           1, 0);

    @(negedge clk);
    step();
    step();
    rst = 0;
    chk("rst_rm", rm_data, 64'h0);
    chk("rst_rn", rn_data, 64'h0);
    chk("rst_valid", {63'h0, rd_valid}, 64'h0);
    chk("rst_hazard", {63'h0, rd_hazard}, 64'h0);
    chk("rst_busy", {63'h0, clr_busy}, 64'h0);
    chk("rst_drop", {63'h0, wr_drop}, 64'h0);

    for (int i = 0; i < NV; i++) begin
      rd_en = vecs[i].rd; rd_wave = vecs[i].rw; rd_cycle = vecs[i].rc;
      rm_addr = vecs[i].rm; rn_addr = vecs[i].rn;
      wr_en = vecs[i].we; wr_wave = vecs[i].ww; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      pend_set = vecs[i].ps; pend_wave = vecs[i].pw; pend_addr = vecs[i].pa;
      step();
      idle();
      chk($sformatf("v%0d_valid", i), {63'h0, rd_valid}, {63'h0, vecs[i].rd});
      chk($sformatf("v%0d_drop", i), {63'h0, wr_drop}, {63'h0, vecs[i].edrop});
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_rm", i), rm_data, vecs[i].erm);
        chk($sformatf("v%0d_rn", i), rn_data, vecs[i].ern);
        chk($sformatf("v%0d_hz", i), {63'h0, rd_hazard}, {63'h0, vecs[i].ehz});
      end
    end

    // Context clear of wave 1 with concurrent writes and an ignored second request.
    for (int a = 0; a < 28; a++) begin
      wr_en = 1; wr_wave = 1; wr_addr = 5'(a); wr_data = 64'h1000 + 64'(a);
      step();
    end
    idle();
    pend_set = 1; pend_wave = 1; pend_addr = 4;
    step();
    idle();
    rd2(1, 4, 27);
    chk("pre_clr_hz", {63'h0, rd_hazard}, 64'h1);
    chk("pre_clr_rn", rn_data, 64'h101B);

    cnt = 0;
    clr_req = 1; clr_wave = 1;
    step();
    idle();
    chk("clr_busy_rise", {63'h0, clr_busy}, 64'h1);
    if (clr_busy) cnt++;
    wr_en = 1; wr_wave = 1; wr_addr = 27; wr_data = 64'h99;
    step();
    idle();
    chk("clr_wr_same_drop", {63'h0, wr_drop}, 64'h1);
    if (clr_busy) cnt++;
    wr_en = 1; wr_wave = 0; wr_addr = 10; wr_data = 64'hAB;
    clr_req = 1; clr_wave = 0;
    step();
    idle();
    chk("clr_wr_other_drop", {63'h0, wr_drop}, 64'h0);
    if (clr_busy) cnt++;
    for (int k = 0; k < 100 && clr_busy; k++) begin
      step();
      if (clr_busy) cnt++;
    end
    chk("clr_cycles", 64'(cnt), 64'd28);

    for (int a = 0; a < 28; a++) begin
      rd2(1, 5'(a), 5'(27 - a));
      chk($sformatf("clr_w1_r%0d", a), rm_data, 64'h0);
      chk($sformatf("clr_w1_hz%0d", a), {63'h0, rd_hazard}, 64'h0);
    end
    rd2(0, 10, 7);
    chk("clr_w0_r10", rm_data, 64'hAB);
    chk("clr_w0_r7", rn_data, 64'h55);

    // Reset while the engine is clearing wave 2 at index 10.
    wr_en = 1; wr_wave = 2; wr_addr = 20; wr_data = 64'h2020;
    step();
    idle();
    clr_req = 1; clr_wave = 2;
    step();
    idle();
    repeat (10) step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_busy", {63'h0, clr_busy}, 64'h0);
    chk("mid_rst_rm", rm_data, 64'h0);
    chk("mid_rst_valid", {63'h0, rd_valid}, 64'h0);
    rd2(2, 20, 5);
    chk("mid_rst_w2r20", rm_data, 64'h0);
    chk("mid_rst_w2r5", rn_data, 64'h0);
    rd2(0, 10, 7);
    chk("mid_rst_w0r10", rm_data, 64'h0);
    chk("mid_rst_w0r7", rn_data, 64'h0);

    cnt = 0;
    clr_req = 1; clr_wave = 3;
    step();
    idle();
    chk("post_rst_clr_accept", {63'h0, clr_busy}, 64'h1);
    if (clr_busy) cnt++;
    for (int k = 0; k < 100 && clr_busy; k++) begin
      step();
      if (clr_busy) cnt++;
    end
    chk("post_rst_clr_cycles", 64'(cnt), 64'd28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/simd_lane_regfile_mw.md
# simd_lane_regfile_mw

Per-lane, multi-wave register file for the SIMD execution unit: one instance sits beside each SIMD lane and holds independent register contexts for up to NUM_WAVES resident waves. It provides two registered read ports and one write port, with same-cycle write-to-read bypass. It also keeps a per-register pending scoreboard for long-latency loads and runs a sequential context-clear engine so a new wave can be launched into a retired slot. Read-only metadata registers (blockIdx, blockDim, threadIdx, zero) are generated per wave context.

## Interface
- DATA_WIDTH, 64, register width
- NUM_REGS, 32, registers per context; top 4 are read-only
- NUM_WAVES, 4, resident wave contexts
- WAVE_SIZE, 32, threads per wave
- LANE_WIDTH, 16, SIMD lanes
- Derived: AW = $clog2(NUM_REGS), WW = max(1,$clog2(NUM_WAVES)), CW = max(1,$clog2(WAVE_SIZE/LANE_WIDTH)), GP = NUM_REGS-4

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lane_id  in  $clog2(LANE_WIDTH)  static lane index
- block_id  in  32  signed block index
- block_dim  in  32  threads per block
- wave_base  in  32  global wave id of context 0; context w is wave wave_base+w
- rd_en  in  1  read request
- rd_wave  in  WW  context read
- rd_cycle  in  CW  wave sub-cycle (which LANE_WIDTH slice)
- rm_addr, rn_addr  in  AW each  source registers
- rm_data, rn_data  out  DATA_WIDTH each  read data
- rd_valid  out  1  read data valid
- rd_hazard  out  1  either source was pending at request time
- wr_en  in  1  write request
- wr_wave  in  WW, wr_addr  in  AW, wr_data  in  DATA_WIDTH
- pend_set  in  1  mark register pending (load issued)
- pend_wave  in  WW, pend_addr  in  AW
- clr_req  in  1  start context clear
- clr_wave  in  WW  context to clear
- clr_busy  out  1  clear engine active
- wr_drop  out  1  pulse: last-cycle write was discarded

## Operation
- Storage: NUM_WAVES x GP general registers; read-only R[GP..GP+3] are not stored.
- Read-only values, for context w:
  - R[GP] = block_id, sign-extended to DATA_WIDTH.
  - R[GP+1] = block_dim, zero-extended.
  - R[GP+2] = thread_id, zero-extended, where thread_id = ((wave_base+w)*WAVE_SIZE + rd_cycle*LANE_WIDTH + lane_id) mod 2^32.
  - R[GP+3] = 0.
- Read: on rd_en, both ports are sampled into output registers.
- Bypass: if wr_en is accepted in the same cycle with wr_wave==rd_wave and wr_addr equals a source address (< GP), that port returns wr_data.
- Write: accepted when wr_en, wr_addr < GP, and not (clr_busy && wr_wave==clr_wave). Any other wr_en is discarded and pulses wr_drop in the next cycle.
- Scoreboard: one pending bit per (wave, GP register).
  - pend_set with pend_addr < GP sets the bit; pend_addr ≥ GP is ignored.
  - An accepted write clears the bit.
  - If set and clear hit the same bit in the same cycle, set wins.
- rd_hazard = OR of the pending bits of rm_addr and rn_addr, sampled before this cycle's updates.
- Clear FSM:
  - States: IDLE, CLEAR.
  - IDLE → CLEAR on clr_req. The engine latches clr_wave and sets index = 0.
  - In CLEAR, one register per cycle: R[index] = 0 and its pending bit = 0.
  - CLEAR → IDLE after index GP-1.
  - clr_req is ignored while in CLEAR.
  - Reads of the clearing context are permitted and return current contents.

## Timing
- Read latency 1: rd_en at edge N → rm_data, rn_data, rd_valid and rd_hazard valid after edge N+1.
- rd_valid is a one-cycle pulse per rd_en. Outputs hold their value while rd_en is low.
- A write at edge N is visible to a non-bypassed read issued at edge N+1 or later.
- Clear takes exactly GP cycles. clr_busy rises after the clr_req edge and falls after the edge that clears R[GP-1].
- Reset (takes effect at a clk edge):
  - All GP registers of all contexts become 0 and all pending bits become 0.
  - FSM returns to IDLE, discarding any clear in progress.
  - rm_data = rn_data = 0; rd_valid = rd_hazard = clr_busy = wr_drop = 0.
  - Requests presented in the reset cycle are ignored.
- Simultaneous clear-engine write and accepted write cannot collide: writes to the clearing context are dropped.

## Test plan
- Write/read: reset; write wave2 R5 = 0xDEAD_BEEF; next cycle read rm = R5, rn = R31 of wave2. Expect rm_data = 0xDEADBEEF, rn_data = 0, rd_valid pulse one cycle later. Same R5 read in wave1 returns 0.
- Bypass and read-only: write wave0 R7 = 0x55 and read R7 in the same cycle → 0x55. Write R29 → ignored, wr_drop = 1.
- Metadata: wave_base = 3, block_id = -1, block_dim = 64, lane_id = 5.
  - Wave1 with rd_cycle = 1: R30 = 4*32+16+5 = 149.
  - R28 = 0xFFFF_FFFF_FFFF_FFFF; R29 = 64.
- Scoreboard: pend_set wave0 R3; read R3 → rd_hazard = 1. Write R3 → next read has rd_hazard = 0. pend_set and write R3 in the same cycle → still pending.
- Clear: fill wave1 R0..R27 with nonzero values and set pending on R4.
  - clr_req wave1: clr_busy high for exactly 28 cycles.
  - A write to wave1 during the clear is dropped; a write to wave0 during the clear succeeds.
  - After the clear, all wave1 registers read 0 and none are pending.
- Reset mid-clear: assert rst at index 10 → clr_busy = 0 next cycle, all registers 0, and a new clr_req is accepted.
